mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single shared memory port of the 31-instruction MIPS core.
- Requester 0 is instruction fetch; requester 1 is load/store.
- Grants one requester at a time and registers that requester's address, write data and write enable onto the port.
- Drives oSel, the select line for the downstream 32-bit 2:1 selectors that route address and data, and returns read data with a completion pulse and a timeout error.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-requester arbiter and sequencer for the single shared memory port of
// the MIPS core. Requester 0 is instruction fetch, requester 1 is load/store.
// One requester owns the port at a time. Its address, write data and write
// enable are registered onto the port. Read data comes back with a one-cycle
// completion pulse. A timeout error pulse is raised if memory never acks.
//
// Ports
//   iClk, iRst_n        clock; synchronous active-low reset
//   iReqX               request from requester X, held until oDoneX
//   iAddrX/iWdataX/iWeX transaction fields from requester X
//   oGntX               requester X owns the port
//   oDoneX              one-cycle completion pulse for requester X
//   oRdata              read data, valid while oDoneX is high
//   oErr                one-cycle pulse with oDoneX when the wait timed out
//   oSel                current or last owner; drives the 2:1 port selectors
//   oMemReq             memory request, high for the whole transaction
//   oMemAddr/oMemWdata/oMemWe  registered port fields
//   iMemAck, iMemRdata  memory completion and read data (used in BUSY only)
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; arbitrate and capture the winning requester
// BUSY  | port frozen on the owner; wait for iMemAck or the timeout
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iReq0,
    input  logic [WIDTH-1:0] iAddr0,
    input  logic [WIDTH-1:0] iWdata0,
    input  logic             iWe0,
    input  logic             iReq1,
    input  logic [WIDTH-1:0] iAddr1,
    input  logic [WIDTH-1:0] iWdata1,
    input  logic             iWe1,
    output logic             oGnt0,
    output logic             oGnt1,
    output logic             oDone0,
    output logic             oDone1,
    output logic [WIDTH-1:0] oRdata,
    output logic             oErr,
    output logic             oSel,
    output logic             oMemReq,
    output logic [WIDTH-1:0] oMemAddr,
    output logic [WIDTH-1:0] oMemWdata,
    output logic             oMemWe,
    input  logic             iMemAck,
    input  logic [WIDTH-1:0] iMemRdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Wide enough for the largest allowed MAX_WAIT (1023).
    localparam int CW = 10;

    logic [0:0]    state;
    logic [CW-1:0] waitCnt;
    logic          lastOwner;
    logic          pick;
    logic          timeoutHit;

    // Winner in IDLE: on a tie, the requester that did not own the port last.
    always_comb begin
        pick = 1'b0;
        if (iReq0 && iReq1) begin
            pick = ~lastOwner;
        end else if (iReq1) begin
            pick = 1'b1;
        end
    end

    assign timeoutHit = (waitCnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            waitCnt   <= '0;
            lastOwner <= 1'b0;
            oGnt0     <= 1'b0;
            oGnt1     <= 1'b0;
            oDone0    <= 1'b0;
            oDone1    <= 1'b0;
            oRdata    <= '0;
            oErr      <= 1'b0;
            oSel      <= 1'b0;
            oMemReq   <= 1'b0;
            oMemAddr  <= '0;
            oMemWdata <= '0;
            oMemWe    <= 1'b0;
        end else begin
            oDone0 <= 1'b0;
            oDone1 <= 1'b0;
            oErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq0 || iReq1) begin
                        state     <= BUSY;
                        waitCnt   <= '0;
                        oGnt0     <= ~pick;
                        oGnt1     <= pick;
                        oSel      <= pick;
                        oMemReq   <= 1'b1;
                        oMemAddr  <= pick ? iAddr1  : iAddr0;
                        oMemWdata <= pick ? iWdata1 : iWdata0;
                        oMemWe    <= pick ? iWe1    : iWe0;
                    end
                end
                BUSY: begin
                    // An ack on the timeout edge still counts as a normal completion.
                    if (iMemAck || timeoutHit) begin
                        state     <= IDLE;
                        oGnt0     <= 1'b0;
                        oGnt1     <= 1'b0;
                        oMemReq   <= 1'b0;
                        oDone0    <= ~oSel;
                        oDone1    <= oSel;
                        lastOwner <= oSel;
                        oRdata    <= iMemAck ? iMemRdata : '0;
                        oErr      <= ~iMemAck;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int MW = 4;

    logic         clk = 1'b0;
    logic         iRst_n = 1'b0;
    logic         iReq0 = 1'b0, iReq1 = 1'b0, iWe0 = 1'b0, iWe1 = 1'b0;
    logic [W-1:0] iAddr0 = '0, iAddr1 = '0, iWdata0 = '0, iWdata1 = '0;
    logic         iMemAck = 1'b0;
    logic [W-1:0] iMemRdata = '0;
    logic         oGnt0, oGnt1, oDone0, oDone1, oErr, oSel, oMemReq, oMemWe;
    logic [W-1:0] oRdata, oMemAddr, oMemWdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
        .iClk(clk), .iRst_n(iRst_n),
        .iReq0(iReq0), .iAddr0(iAddr0), .iWdata0(iWdata0), .iWe0(iWe0),
        .iReq1(iReq1), .iAddr1(iAddr1), .iWdata1(iWdata1), .iWe1(iWe1),
        .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
        .oRdata(oRdata), .oErr(oErr), .oSel(oSel), .oMemReq(oMemReq),
        .oMemAddr(oMemAddr), .oMemWdata(oMemWdata), .oMemWe(oMemWe),
        .iMemAck(iMemAck), .iMemRdata(iMemRdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {gnt0, gnt1, done0, done1, err, sel, memReq}
    function automatic logic [6:0] st7();
        return {oGnt0, oGnt1, oDone0, oDone1, oErr, oSel, oMemReq};
    endfunction

    typedef struct {
        logic         rstN;
        logic         req0;
        logic         req1;
        logic         ack;
        logic [W-1:0] rdata;
        logic [6:0]   expSt;
        logic [W-1:0] expRdata;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic q0, input logic q1, input logic a,
                                input logic [W-1:0] rd, input logic [6:0] st, input logic [W-1:0] erd);
        vec_t v;
        v.rstN = r; v.req0 = q0; v.req1 = q1; v.ack = a;
        v.rdata = rd; v.expSt = st; v.expRdata = erd;
        return v;
    endfunction

    // Reference model: who owns the port and how long it has waited.
    int           mOwner, mWaited, mLast;
    logic         eDone0, eDone1, eErr, eSel, eWe;
    logic [W-1:0] eAddr, eWdata, eRdata;

    task automatic modelStep();
        int w;
        if (!iRst_n) begin
            mOwner = -1; mWaited = 0; mLast = 0;
            eDone0 = 0; eDone1 = 0; eErr = 0; eSel = 0; eWe = 0;
            eAddr = '0; eWdata = '0; eRdata = '0;
        end else begin
            eDone0 = 0; eDone1 = 0; eErr = 0;
            if (mOwner < 0) begin
                if (iReq0 || iReq1) begin
                    if (iReq0 && iReq1) w = 1 - mLast;
                    else                w = iReq1 ? 1 : 0;
                    mOwner = w; mWaited = 0; eSel = (w == 1);
                    eAddr  = (w == 1) ? iAddr1  : iAddr0;
                    eWdata = (w == 1) ? iWdata1 : iWdata0;
                    eWe    = (w == 1) ? iWe1    : iWe0;
                end
            end else if (iMemAck || (mWaited + 1 >= MW)) begin
                eDone0 = (mOwner == 0);
                eDone1 = (mOwner == 1);
                eErr   = !iMemAck;
                eRdata = iMemAck ? iMemRdata : '0;
                mLast  = mOwner;
                mOwner = -1;
            end else begin
                mWaited++;
            end
        end
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = mk(0, 1, 1, 0, 32'h0,  7'b0000000, 32'h0);
        tbl[1]  = mk(0, 1, 1, 0, 32'h0,  7'b0000000, 32'h0);
        tbl[2]  = mk(1, 1, 1, 0, 32'h0,  7'b0100011, 32'h0);
        tbl[3]  = mk(1, 1, 1, 1, 32'h11, 7'b0001010, 32'h11);
        tbl[4]  = mk(1, 1, 1, 0, 32'h0,  7'b1000001, 32'h11);
        tbl[5]  = mk(1, 1, 1, 1, 32'h22, 7'b0010000, 32'h22);
        tbl[6]  = mk(1, 1, 1, 0, 32'h0,  7'b0100011, 32'h22);
        tbl[7]  = mk(1, 1, 1, 1, 32'h33, 7'b0001010, 32'h33);
        tbl[8]  = mk(1, 1, 0, 0, 32'h0,  7'b1000001, 32'h33);
        tbl[9]  = mk(1, 0, 0, 0, 32'h0,  7'b1000001, 32'h33);
        tbl[10] = mk(1, 0, 0, 1, 32'h44, 7'b0010000, 32'h44);
        tbl[11] = mk(1, 0, 0, 1, 32'h55, 7'b0000000, 32'h44);
        tbl[12] = mk(1, 0, 1, 0, 32'h0,  7'b0100011, 32'h44);
        tbl[13] = mk(0, 0, 1, 0, 32'h0,  7'b0000000, 32'h0);
        tbl[14] = mk(1, 0, 0, 0, 32'h0,  7'b0000000, 32'h0);

        iAddr0 = 32'h100; iAddr1 = 32'h200;
        #1;
        for (int i = 0; i < 15; i++) begin
            iRst_n = tbl[i].rstN; iReq0 = tbl[i].req0; iReq1 = tbl[i].req1;
            iMemAck = tbl[i].ack; iMemRdata = tbl[i].rdata;
            tick();
            chk($sformatf("tbl%0d_status", i), 64'(st7()), 64'(tbl[i].expSt));
            chk($sformatf("tbl%0d_rdata", i), 64'(oRdata), 64'(tbl[i].expRdata));
        end
        iMemAck = 0;

        // Single load, acked three cycles after the request rose.
        iReq1 = 1; iAddr1 = 32'h1000_0004; iWe1 = 0; iWdata1 = 32'h0;
        tick();
        chk("load_grant", 64'({oGnt1, oMemReq, oSel, oMemWe}), 64'(4'b1110));
        chk("load_addr0", 64'(oMemAddr), 64'(32'h1000_0004));
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk($sformatf("load_wait%0d", k), 64'({oGnt1, oDone1, oMemAddr}), 64'({2'b10, 32'h1000_0004}));
        end
        iMemAck = 1; iMemRdata = 32'hDEAD_BEEF;
        tick();
        chk("load_done", 64'({oDone1, oErr, oGnt1, oMemReq}), 64'(4'b1000));
        chk("load_rdata", 64'(oRdata), 64'(32'hDEAD_BEEF));
        iReq1 = 0; iMemAck = 0;
        tick();
        chk("load_done_once", 64'({oDone1, oDone0, oMemReq}), 64'(3'b000));

        // Inputs changed and request dropped mid-transaction.
        iReq0 = 1; iAddr0 = 32'h80; iWe0 = 0;
        tick();
        chk("mid_grant", 64'({oGnt0, oSel, oMemAddr}), 64'({2'b10, 32'h80}));
        iAddr0 = 32'h40; iReq0 = 0;
        tick();
        chk("mid_frozen", 64'({oGnt0, oMemAddr}), 64'({1'b1, 32'h80}));
        iMemAck = 1; iMemRdata = 32'h1234;
        tick();
        chk("mid_done", 64'({oDone0, oErr, oGnt0}), 64'(3'b100));
        iMemAck = 0;
        tick();

        // Timeout: never acked.
        iReq0 = 1; iAddr0 = 32'h300;
        tick();
        chk("to_grant", 64'({oGnt0, oMemReq}), 64'(2'b11));
        iReq0 = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("to_wait%0d", k), 64'({oGnt0, oDone0, oErr}), 64'(3'b100));
        end
        tick();
        chk("to_abort", 64'({oGnt0, oDone0, oErr, oMemReq}), 64'(4'b0110));
        chk("to_rdata", 64'(oRdata), 64'(0));
        tick();
        chk("to_pulse_end", 64'({oDone0, oErr}), 64'(2'b00));

        // Ack on the timeout edge wins.
        iReq0 = 1;
        tick();
        iReq0 = 0;
        for (int k = 1; k <= 3; k++) tick();
        iMemAck = 1; iMemRdata = 32'hCAFE_F00D;
        tick();
        chk("to_ack_wins", 64'({oDone0, oErr}), 64'(2'b10));
        chk("to_ack_rdata", 64'(oRdata), 64'(32'hCAFE_F00D));
        iMemAck = 0;

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iRst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            if (oDone0) iReq0 = 0;
            else if (!iReq0 && $urandom_range(0, 3) == 0) begin
                iReq0 = 1; iAddr0 = $urandom; iWdata0 = $urandom; iWe0 = ($urandom_range(0, 7) == 0);
            end else if ($urandom_range(0, 7) == 0) iAddr0 = $urandom;
            if (oDone1) iReq1 = 0;
            else if (!iReq1 && $urandom_range(0, 2) == 0) begin
                iReq1 = 1; iAddr1 = $urandom; iWdata1 = $urandom; iWe1 = $urandom_range(0, 1) == 1;
            end else if ($urandom_range(0, 7) == 0) iWdata1 = $urandom;
            iMemAck = ($urandom_range(0, 2) == 0);
            iMemRdata = $urandom;
            modelStep();
            tick();
            chk($sformatf("rnd%0d_status", cyc),
                64'({oGnt0, oGnt1, oDone0, oDone1, oErr, oSel, oMemReq, oMemWe}),
                64'({mOwner == 0, mOwner == 1, eDone0, eDone1, eErr, eSel, mOwner >= 0, eWe}));
            chk($sformatf("rnd%0d_port", cyc), 64'({oMemAddr, oMemWdata}), 64'({eAddr, eWdata}));
            chk($sformatf("rnd%0d_rdata", cyc), 64'(oRdata), 64'(eRdata));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
